debounce_fsm: RTL
=================

# debounce_fsm

Debounces a raw, asynchronous mechanical input (switch/button) before it reaches the dual-edge detector. Provides a two-flop synchronizer, a stability counter and a four-state Moore FSM. Its clean level output `o_db_lvl` connects directly to the detector's `i_lvl`. The detector then converts each accepted level change into a single-cycle `o_edge`.

## Interface
- `STABLE_CYCLES`, default 1_000_000: number of consecutive synchronized samples, beyond the first, needed to accept a level change. 20 ms at the 50 MHz / 20 ns system clock. Legal range is 1 or greater; benches override it with small values.
- `CNT_W`, default `$clog2(STABLE_CYCLES+1)`: stability counter width. Derived; never overridden.

Ports:
- `i_clk`, in, 1: system clock; all logic is on the rising edge.
- `i_rst_n`, in, 1: reset, synchronous, active-low.
- `i_lvl`, in, 1: raw asynchronous bouncing input.
- `o_db_lvl`, out, 1: debounced level; feeds the edge detector's `i_lvl`.
- `o_busy`, out, 1: high while a candidate transition is being qualified (`WAIT1` or `WAIT0`).

## Operation
- **Synchronizer.** Two flops, `sync1 <= i_lvl` and `sync2 <= sync1`. The FSM only ever sees `s = sync2`; `i_lvl` is never used combinationally.
- **Counter.** `cnt` is `CNT_W` bits wide. It is cleared on entry to any WAIT state and increments once per cycle while in a WAIT state. It never wraps, because the exit condition fires at `STABLE_CYCLES-1`.
- **FSM states.** Binary-encoded: `ZERO`, `WAIT1`, `ONE`, `WAIT0`.
- **`ZERO`**
  - `s=1`: go to `WAIT1` and set `cnt=0`.
  - Otherwise stay in `ZERO`.
- **`WAIT1`**
  - `s=0`: glitch rejected; return to `ZERO`.
  - `s=1` and `cnt==STABLE_CYCLES-1`: go to `ONE`.
  - Otherwise `cnt` increments.
- **`ONE`**
  - `s=0`: go to `WAIT0` and set `cnt=0`.
  - Otherwise stay in `ONE`.
- **`WAIT0`**
  - `s=1`: glitch rejected; return to `ONE`.
  - `s=0` and `cnt==STABLE_CYCLES-1`: go to `ZERO`.
  - Otherwise `cnt` increments.
- **Outputs (Moore decode of the state register only).**
  - `o_db_lvl = (state==ONE) || (state==WAIT0)`.
  - `o_busy = (state==WAIT1) || (state==WAIT0)`.
- **Reset.** When `i_rst_n=0` at a rising edge:
  - `sync1`, `sync2`, `cnt` and `state` go to 0 / `ZERO`.
  - Resulting outputs are `o_db_lvl=0` and `o_busy=0`.
  - Reset has priority over every transition.
- **Reset mid-operation.** Any qualification in progress is discarded. If `i_lvl` is held high through reset release, the block re-qualifies it from `ZERO` with full latency. There is no shortcut to `ONE`.
- **Restart behaviour.** A single opposite sample during WAIT aborts qualification. The next qualification restarts with `cnt=0`; no partial credit is kept.

## Timing
- **Reference edge.** Let `E0` be the first rising edge at which `sync1` captures a new value `v`.
- **Synchronizer delay.** `s` reflects the `E(k)` sample at edge `E(k+2)`.
- **Rise latency.**
  - `WAIT1` is entered at `E2`.
  - `ONE` is entered at `E(N+2)`, where `N = STABLE_CYCLES`.
  - This requires the `N+1` consecutive samples at `E0..E(N)` to all equal 1.
- **Resulting latency.** `o_db_lvl` changes exactly `N+2` cycles after `E0`. `o_busy` is high for exactly `N` cycles (`E2` up to `E(N+2)`).
- **Fall.** Symmetric to rise, using `WAIT0` and the same `N+2` latency.
- **Glitch rejection.** Any input pulse shorter than `N+1` consecutive samples produces no change on `o_db_lvl`.
  - A pulse of 1 to `N` cycles gives `o_busy` high for the same number of cycles.
- **`o_db_lvl` is glitch-free.** It changes at most once per accepted transition, which gives the downstream dual-edge detector exactly one `o_edge` per accepted press or release.
- **Minimum spacing.** Accepted `o_db_lvl` transitions are at least `N+1` cycles apart.

## Test plan
All scenarios use `STABLE_CYCLES=4`, a 20 ns clock, and `i_lvl` driven at `negedge`.

- **Reset.** Hold `i_rst_n=0` for 3 cycles with `i_lvl=1`, then release.
  - `o_db_lvl=0` and `o_busy=0` during reset.
  - After release, `o_db_lvl` rises 6 cycles after the first post-release sample.
- **Clean press.** Raise `i_lvl` from 0 and hold it for 10 cycles.
  - `o_db_lvl` rises exactly 6 cycles after the sampling edge.
  - `o_busy` is high for exactly 4 cycles.
  - The attached detector produces one `o_edge`.
- **Short pulses.** Pulses of 1, 2, 3 and 4 cycles, separated by 10 low cycles.
  - `o_db_lvl` stays 0 throughout.
  - `o_busy` pulses last 1, 2, 3 and 4 cycles respectively.
- **Bounce then settle.** Drive 1,0,1,1,0 (one cycle each), then hold 1.
  - `o_db_lvl` rises 6 cycles after the start of the final stable run.
  - There is exactly one rising transition.
- **Release bounce.** From a debounced 1, drive 0,1,0,0,1 then hold 0.
  - `o_db_lvl` stays 1 through the bounce.
  - It falls 6 cycles after the final run starts.
- **Reset mid-qualification.** Assert `i_rst_n=0` while `cnt=2` in `WAIT1`.
  - On the next edge: `state=ZERO`, `o_busy=0`, `o_db_lvl=0`.
- **Random soak.** 20 random pulses of 10–150 ns each, as in the detector bench.
  - A scoreboard model matches `o_db_lvl` every cycle.

Source files
------------

// File: rtl/debounce_fsm.sv
// Debouncer for a raw mechanical input: two-flop synchronizer, stability counter and
// a four-state Moore FSM whose clean level feeds the dual-edge detector.
module debounce_fsm #(
   parameter int STABLE_CYCLES = 1_000_000,
   parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_lvl,
   output logic o_db_lvl,
   output logic o_busy
);

   typedef enum logic [1:0] {
      ZERO  = 2'd0,
      WAIT1 = 2'd1,
      ONE   = 2'd2,
      WAIT0 = 2'd3
   } state_t;

   // Qualification ends when the counter reaches this value with the input still agreeing.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_s;

   assign w_s = r_sync2;

   // NOTE: non-blocking assignments so every flop samples pre-edge values; the
   // synchronizer stages would collapse into one flop with blocking assignments.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_cnt   <= '0;
         r_state <= ZERO;
      end else begin
         r_sync1 <= i_lvl;
         r_sync2 <= r_sync1;
         r_cnt   <= w_cnt_nxt;
         r_state <= w_state_nxt;
      end
   end

   // NOTE: every output of this block is defaulted first so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         ZERO: begin
            if (w_s) begin
               w_state_nxt = WAIT1;
               w_cnt_nxt   = '0;
            end
         end
         WAIT1: begin
            if (!w_s) begin
               w_state_nxt = ZERO;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = ONE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ONE: begin
            if (!w_s) begin
               w_state_nxt = WAIT0;
               w_cnt_nxt   = '0;
            end
         end
         WAIT0: begin
            if (w_s) begin
               w_state_nxt = ONE;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = ZERO;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ZERO;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Moore decode from the state register only, so o_db_lvl cannot glitch.
   always_comb begin
      o_db_lvl = (r_state == ONE) || (r_state == WAIT0);
      o_busy   = (r_state == WAIT1) || (r_state == WAIT0);
   end

endmodule
